// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: opcodes, IR field positions, sequencer states and opcode classes
package cpu_defs_pkg;
    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;
    localparam int IR_C_MSB  = 18;
    localparam int IR_C_LSB  = 0;
    localparam int OPCODE_W  = IR_OP_MSB - IR_OP_LSB + 1;

    localparam logic [OPCODE_W-1:0] OP_LD   = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_SHRA = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'd9;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'd10;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'd11;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd12;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'd13;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'd15;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'd16;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 5'd17;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'd18;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT_S
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU3, CL_IMM, CL_MULDIV, CL_UNARY, CL_LDI, CL_LD, CL_ST, CL_NOP, CL_HALT
    } op_class_t;
endpackage

// File: rtl/opcode_class_decode.sv
// opcode_class_decode: maps an opcode to its execute-sequence class
module opcode_class_decode
    import cpu_defs_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output op_class_t           o_class
);
    always_comb
        o_class = (i_opcode inside {[OP_ADD:OP_OR]})   ? CL_ALU3   :
                  (i_opcode inside {[OP_ADDI:OP_ORI]}) ? CL_IMM    :
                  (i_opcode inside {OP_MUL, OP_DIV})   ? CL_MULDIV :
                  (i_opcode inside {OP_NEG, OP_NOT})   ? CL_UNARY  :
                  (i_opcode == OP_LDI)                 ? CL_LDI    :
                  (i_opcode == OP_LD)                  ? CL_LD     :
                  (i_opcode == OP_ST)                  ? CL_ST     :
                  (i_opcode == OP_HALT)                ? CL_HALT   : CL_NOP;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping fetch and opcode-specific execute T-steps
module control_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int IR_W = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [IR_W-1:0] ir,
    input  logic            stop,
    output logic            pc_out,
    output logic            zlo_out,
    output logic            zhi_out,
    output logic            mdr_out,
    output logic            c_out,
    output logic            lo_out,
    output logic            hi_out,
    output logic            mar_enable,
    output logic            z_enable,
    output logic            y_enable,
    output logic            pc_enable,
    output logic            mdr_enable,
    output logic            ir_enable,
    output logic            lo_enable,
    output logic            hi_enable,
    output logic            pc_increment,
    output logic            read,
    output logic            write,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            r_in,
    output logic            r_out,
    output logic            ba_out,
    output logic [OP_W-1:0] op_code,
    output logic            run
);
    state_t          r_state;
    state_t          w_next;
    state_t          w_last;
    state_t          w_step_next;
    logic            r_stop_pending;
    op_class_t       w_class;
    logic [OP_W-1:0] w_opcode;
    logic            w_unused_ir;

    assign w_opcode    = ir[IR_W-1 -: OP_W];
    assign w_unused_ir = ^ir[IR_W-OP_W-1:0];

    opcode_class_decode u_decode (
        .i_opcode (w_opcode),
        .o_class  (w_class)
    );

    // Final execute step per class; the step after it is T0, or HALT_S on halt/stop
    assign w_last = (w_class == CL_MULDIV)                ? T6 :
                    (w_class == CL_UNARY)                 ? T4 :
                    (w_class inside {CL_LD, CL_ST})       ? T7 :
                    (w_class inside {CL_NOP, CL_HALT})    ? T3 : T5;
    assign w_step_next = (r_state != w_last) ? state_t'(r_state + 4'd1) :
                         (w_class == CL_HALT || r_stop_pending || stop) ? HALT_S : T0;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state        <= RESET_S;
            r_stop_pending <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_stop_pending <= r_stop_pending | stop;
        end
    end

    always_comb begin
        {pc_out, zlo_out, zhi_out, mdr_out, c_out, lo_out, hi_out} = '0;
        {mar_enable, z_enable, y_enable, pc_enable, mdr_enable, ir_enable, lo_enable, hi_enable} = '0;
        {pc_increment, read, write, gra, grb, grc, r_in, r_out, ba_out} = '0;
        op_code = '0;
        run     = 1'b1;
        w_next  = r_state;
        case (r_state)
            RESET_S: w_next = T0;
            T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; w_next = T1; end
            T1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; w_next = T2; end
            T2: begin mdr_out = 1'b1; ir_enable = 1'b1; w_next = T3; end
            T3: begin
                w_next = w_step_next;
                case (w_class)
                    CL_ALU3, CL_IMM: begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                    CL_MULDIV: begin gra = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                    CL_UNARY: begin grb = 1'b1; r_out = 1'b1; op_code = w_opcode; z_enable = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                w_next = w_step_next;
                case (w_class)
                    CL_ALU3: begin grc = 1'b1; r_out = 1'b1; op_code = w_opcode; z_enable = 1'b1; end
                    CL_IMM: begin c_out = 1'b1; op_code = w_opcode; z_enable = 1'b1; end
                    CL_MULDIV: begin grb = 1'b1; r_out = 1'b1; op_code = w_opcode; z_enable = 1'b1; end
                    CL_UNARY: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin c_out = 1'b1; op_code = OP_ADD; z_enable = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                w_next = w_step_next;
                case (w_class)
                    CL_ALU3, CL_IMM, CL_LDI: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CL_MULDIV: begin zlo_out = 1'b1; lo_enable = 1'b1; end
                    CL_LD, CL_ST: begin zlo_out = 1'b1; mar_enable = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                w_next = w_step_next;
                case (w_class)
                    CL_MULDIV: begin zhi_out = 1'b1; hi_enable = 1'b1; end
                    CL_LD: begin read = 1'b1; mdr_enable = 1'b1; end
                    CL_ST: begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
                    default: ;
                endcase
            end
            T7: begin
                w_next = w_step_next;
                case (w_class)
                    CL_LD: begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CL_ST: write = 1'b1;
                    default: ;
                endcase
            end
            default: begin run = 1'b0; w_next = HALT_S; end
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks against a step-list model of the sequencer
module tb_control_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic stop = 1'b0;
    logic [31:0] ir = '0;
    logic pc_out, zlo_out, zhi_out, mdr_out, c_out, lo_out, hi_out;
    logic mar_enable, z_enable, y_enable, pc_enable, mdr_enable, ir_enable, lo_enable, hi_enable;
    logic pc_increment, read, write, gra, grb, grc, r_in, r_out, ba_out, run;
    logic [4:0] op_code;
    logic [29:0] act;
    logic [4:0] opc;
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
        .c_out(c_out), .lo_out(lo_out), .hi_out(hi_out),
        .mar_enable(mar_enable), .z_enable(z_enable), .y_enable(y_enable), .pc_enable(pc_enable),
        .mdr_enable(mdr_enable), .ir_enable(ir_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
        .pc_increment(pc_increment), .read(read), .write(write),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .op_code(op_code), .run(run)
    );

    assign act = {pc_out, zlo_out, zhi_out, mdr_out, c_out, lo_out, hi_out,
                  mar_enable, z_enable, y_enable, pc_enable, mdr_enable, ir_enable, lo_enable, hi_enable,
                  pc_increment, read, write, gra, grb, grc, r_in, r_out, ba_out, op_code, run};
    assign opc = ir[31:27];

    localparam logic [29:0] B_RUN = 30'd1;
    localparam logic [29:0] B_BA = 30'd1 << 6, B_ROUT = 30'd1 << 7, B_RIN = 30'd1 << 8;
    localparam logic [29:0] B_GRC = 30'd1 << 9, B_GRB = 30'd1 << 10, B_GRA = 30'd1 << 11;
    localparam logic [29:0] B_WRITE = 30'd1 << 12, B_READ = 30'd1 << 13, B_PCI = 30'd1 << 14;
    localparam logic [29:0] B_HIEN = 30'd1 << 15, B_LOEN = 30'd1 << 16, B_IREN = 30'd1 << 17;
    localparam logic [29:0] B_MDREN = 30'd1 << 18, B_PCEN = 30'd1 << 19, B_YEN = 30'd1 << 20;
    localparam logic [29:0] B_ZEN = 30'd1 << 21, B_MAR = 30'd1 << 22, B_HI = 30'd1 << 23;
    localparam logic [29:0] B_LO = 30'd1 << 24, B_COUT = 30'd1 << 25, B_MDR = 30'd1 << 26;
    localparam logic [29:0] B_ZHI = 30'd1 << 27, B_ZLO = 30'd1 << 28, B_PC = 30'd1 << 29;

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Clocks per instruction, counting fetch; halt and unknown opcodes end after T3
    function automatic int cpi(input logic [4:0] op);
        if (op == 1 || (op >= 3 && op <= 14)) return 6;
        if (op == 15 || op == 16) return 7;
        if (op == 17 || op == 18) return 5;
        if (op == 0 || op == 2) return 8;
        return 4;
    endfunction

    // Control word of step idx of an instruction with opcode op (step 0 = T0)
    function automatic logic [29:0] exp_word(input logic [4:0] op, input int idx);
        logic [29:0] s [8];
        logic [29:0] opw;
        opw = {24'd0, op, 1'b0};
        for (int i = 0; i < 8; i++) s[i] = B_RUN;
        s[0] |= B_PC | B_MAR | B_PCI | B_ZEN;
        s[1] |= B_ZLO | B_PCEN | B_READ | B_MDREN;
        s[2] |= B_MDR | B_IREN;
        if (op >= 3 && op <= 11) begin
            s[3] |= B_GRB | B_ROUT | B_YEN;
            s[4] |= B_GRC | B_ROUT | opw | B_ZEN;
            s[5] |= B_ZLO | B_GRA | B_RIN;
        end else if (op >= 12 && op <= 14) begin
            s[3] |= B_GRB | B_ROUT | B_YEN;
            s[4] |= B_COUT | opw | B_ZEN;
            s[5] |= B_ZLO | B_GRA | B_RIN;
        end else if (op == 15 || op == 16) begin
            s[3] |= B_GRA | B_ROUT | B_YEN;
            s[4] |= B_GRB | B_ROUT | opw | B_ZEN;
            s[5] |= B_ZLO | B_LOEN;
            s[6] |= B_ZHI | B_HIEN;
        end else if (op == 17 || op == 18) begin
            s[3] |= B_GRB | B_ROUT | opw | B_ZEN;
            s[4] |= B_ZLO | B_GRA | B_RIN;
        end else if (op <= 2) begin
            s[3] |= B_GRB | B_BA | B_YEN;
            s[4] |= B_COUT | {24'd0, 5'd3, 1'b0} | B_ZEN;
            s[5] |= (op == 1) ? (B_ZLO | B_GRA | B_RIN) : (B_ZLO | B_MAR);
            if (op == 0) begin
                s[6] |= B_READ | B_MDREN;
                s[7] |= B_MDR | B_GRA | B_RIN;
            end
            if (op == 2) begin
                s[6] |= B_GRA | B_ROUT | B_MDREN;
                s[7] |= B_WRITE;
            end
        end
        return s[idx];
    endfunction

    // Model: 0 unknown, 1 reset, 2 running step m_step of current instruction, 3 halted
    int m_mode = 0;
    int m_step = 0;
    logic m_pend = 1'b0;

    always @(posedge clk) begin
        if (clr) begin
            m_mode <= 1;
            m_pend <= 1'b0;
        end else if (m_mode != 0) begin
            m_pend <= m_pend | stop;
            if (m_mode == 1) begin
                m_mode <= 2;
                m_step <= 0;
            end else if (m_mode == 2) begin
                if (m_step == cpi(opc) - 1) begin
                    if (opc == 5'b11011 || m_pend || stop) m_mode <= 3;
                    else m_step <= 0;
                end else m_step <= m_step + 1;
            end
        end
    end

    always @(negedge clk)
        if (m_mode != 0)
            check("step", {2'b0, act}, {2'b0, (m_mode == 1) ? B_RUN : (m_mode == 3) ? 30'd0 : exp_word(opc, m_step)});

    logic [29:0] tr [16];

    // Starts and ends at the negedge of a T0 step; records each step's control word
    task automatic run_inst(input string nm, input logic [31:0] v, input int cpi_exp);
        int n;
        #1 ir = v;
        tr[0] = act;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n < 16) tr[n] = act;
        end while (!pc_increment && n < 20);
        check({nm, " cpi"}, n, cpi_exp);
    endtask

    task automatic do_clr();
        #1 clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        int halted;
        logic t0;
        logic [4:0] rop;
        repeat (2) @(negedge clk);
        check("reset word", {2'b0, act}, 32'h1);
        #1 clr = 1'b0;
        @(negedge clk);
        check("first T0", {2'b0, act}, {2'b0, B_RUN | B_PC | B_MAR | B_PCI | B_ZEN});

        run_inst("add", 32'h1A920000, 6);
        check("add T4 op_code", {27'd0, tr[4][5:1]}, 3);
        check("add T4 grc", {31'd0, tr[4][9]}, 1);
        check("add T5 r_in", {31'd0, tr[5][8]}, 1);
        run_inst("div", 32'h81300000, 7);
        check("div T4 op_code", {27'd0, tr[4][5:1]}, 16);
        check("div T5 lo_enable", {31'd0, tr[5][16]}, 1);
        check("div T6 hi_enable", {31'd0, tr[6][15]}, 1);
        run_inst("ld", 32'h00980055, 8);
        check("ld T3 ba_out", {31'd0, tr[3][6]}, 1);
        check("ld T4 op_code", {27'd0, tr[4][5:1]}, 3);
        check("ld T7 r_in", {31'd0, tr[7][8]}, 1);
        run_inst("neg", 32'h88000000, 5);
        run_inst("nop", 32'hD0000000, 4);
        check("nop T3 word", {2'b0, tr[3]}, 32'h1);
        run_inst("addi", 32'h60000000, 6);
        run_inst("ldi", 32'h08000000, 6);
        run_inst("undef", 32'hA0000000, 4);
        run_inst("st", 32'h10980055, 8);
        check("st T6 read", {31'd0, tr[6][13]}, 0);
        check("st T6 mdr_enable", {31'd0, tr[6][18]}, 1);
        check("st T7 write", {31'd0, tr[7][12]}, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) seen |= tr[i][8];
        check("st no r_in", {31'd0, seen}, 0);

        #1 ir = 32'hD8000000;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            #1 ir = $urandom;
            @(negedge clk);
        end
        check("halt hold run", {31'd0, run}, 0);
        do_clr();

        #1 ir = 32'h1A920000;
        repeat (4) @(negedge clk);
        #1 stop = 1'b1;
        @(negedge clk);
        check("stop T5 r_in", {31'd0, r_in}, 1);
        #1 stop = 1'b0;
        @(negedge clk);
        check("stop halts", {2'b0, act}, 0);
        do_clr();

        #1 ir = 32'h78000000;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= lo_enable | hi_enable;
        end
        #1 clr = 1'b1;
        @(negedge clk);
        check("mul clr reset", {2'b0, act}, 32'h1);
        #1 clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen |= lo_enable | hi_enable;
        end
        check("mul clr no lo/hi", {31'd0, seen}, 0);

        halted = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            halted = (run == 1'b0) ? halted + 1 : 0;
            t0 = pc_increment;
            #1;
            stop = ($urandom_range(0, 24) == 0);
            clr = (halted > 3) || ($urandom_range(0, 149) == 0);
            if (t0) begin
                rop = 5'($urandom_range(0, 31));
                if (rop == 5'b11011 && $urandom_range(0, 3) != 0) rop = 5'd3;
                ir = {rop, 27'($urandom)};
            end
        end
        #1 clr = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
